cci_mpf_shim_vtp_svc_arb: RTL and testbench
===========================================

Name: cci_mpf_shim_vtp_svc_arb

Overview:
Shares one VTP translation service instance among N VTP pipeline shims. Each client request carries a client-local tag. The block buffers it, arbitrates round-robin, allocates a unique service tag and forwards the request to the service. Out-of-order service responses are routed back to the originating client, the client's own tag is restored, and the service tag is freed.

Parameters:
N_CLIENTS, 2, number of VTP shim clients (1..8)
N_SVC_TAGS, 8, service tags in flight; equals the service's max outstanding requests
CLIENT_TAG_BITS, 3, width of each client's local tag

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
c_lookupEn  in  N_CLIENTS  per-client request valid
c_lookupPageVA  in  36*N_CLIENTS  4KB VA page index, client i at [36*i +: 36]
c_lookupTag  in  CLIENT_TAG_BITS*N_CLIENTS  client-local tag
c_lookupRdy  out  N_CLIENTS  per-client ready
c_rspValid  out  N_CLIENTS  one-hot response valid
c_rspPagePA  out  26  translated 4KB PA page index (shared by all clients)
c_rspTag  out  CLIENT_TAG_BITS  restored client tag (shared)
c_rspIsBigPage  out  1  2MB translation flag (shared)
s_lookupEn  out  1  service request valid
s_lookupPageVA  out  36  VA page index to the service
s_lookupTag  out  log2(N_SVC_TAGS)  service tag
s_lookupRdy  in  1  service ready
s_rspValid  in  1  service response valid
s_rspPagePA  in  26  PA page index
s_rspTag  in  log2(N_SVC_TAGS)  service tag of the response
s_rspIsBigPage  in  1  big page flag
err_badTag  out  1  sticky flag: a response arrived with an unallocated tag

Behaviour:
- Reset (async assert, sync release): all outputs 0; all hold registers empty; all tags free; round-robin pointer set to 0; err_badTag cleared.
- Handshakes:
  - A transfer occurs when En && Rdy in the same cycle, on both the client side and the service side.
  - The service never backpressures responses.
- Per-client hold register (1 entry):
  - c_lookupRdy[i] = hold_i empty AND not in reset. The value is registered, with no combinational path from any input.
  - On a transfer, VA and tag load at the clock edge.
  - The hold register clears at the edge on which it is granted.
- Output register for s_lookup*:
  - The register may load when it is empty, or when it is being accepted this cycle (s_lookupEn && s_lookupRdy).
  - s_lookupEn holds steady with stable payload until accepted.
- Grant (combinational, evaluated each cycle). A grant requires all of the following:
  - the output register may load;
  - at least one tag is free;
  - at least one hold register is full.
- Grant selection:
  - The winner is the first full hold register found scanning from ptr upward, mod N_CLIENTS.
  - After a grant, ptr = winner + 1 mod N_CLIENTS. Without a grant, ptr is unchanged.
- Tag allocation:
  - The lowest-index free tag is allocated.
  - A table entry records {clientId, clientTag}, and the tag is marked busy at the grant edge.
- Latency:
  - Client transfer at cycle t → s_lookupEn asserted at t+2 at the earliest.
  - Back-to-back grants are possible every cycle while the service is ready and tags are free.
- Response path:
  - s_rspValid at cycle t → c_rspValid[clientId] = 1 at t+1 (one-hot), with c_rspTag = clientTag, and PA and big page flag registered.
  - The tag is freed at the t edge and may be reallocated by a grant in cycle t+1.
  - c_rspValid is 0 in any cycle without a preceding valid response.
- Simultaneous events:
  - A response freeing tag k and a grant allocating a different tag at the same edge are both honoured.
  - A grant in the same cycle as a free cannot take the freed tag; it becomes allocatable the next cycle.
- Bad tag: s_rspValid with an s_rspTag that is not busy:
  - no c_rspValid is produced;
  - err_badTag is set and stays set until reset.
- Tags exhausted (all N_SVC_TAGS busy):
  - no grants occur;
  - hold registers stay full, so those clients see c_lookupRdy = 0.
- Reset mid-operation: all in-flight state is dropped; later service responses for pre-reset tags raise err_badTag.

Test Plan:
- Single request: client 1 sends VA 0x123456789, tag 5; the service responds PA 0x0ABCDEF, big page 1, with tag 0 → s_lookupTag 0 at t+2; c_rspValid = 2'b10, c_rspTag 5, PA 0x0ABCDEF, c_rspIsBigPage 1.
- Fairness: both clients hold requests continuously and s_lookupRdy = 1 → service order alternates 0,1,0,1; tags 0,1,2,3 are allocated in order.
- Exhaustion: 8 requests with no responses → 9th request not issued; after a response with s_rspTag 3, the next grant uses tag 3 one cycle later.
- Out of order: tags 0,1,2 (clients 0,1,0) are answered in order 2,0,1 → c_rspValid sequence 01,01,10, with each client tag restored.
- Backpressure: s_lookupRdy = 0 for 5 cycles → s_lookupEn and payload stay stable; exactly one acceptance once rdy returns.
- Bad tag and reset: a response with tag 6 while it is unallocated → err_badTag = 1, no c_rspValid; assert reset_n = 0 mid-flight → all outputs 0 immediately, tags all free after release.

Source files
------------

// File: rtl/cci_mpf_shim_vtp_svc_arb.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_shim_vtp_svc_arb
// Brief    : Round-robin sharing of one VTP translation service among N shims,
//            with service-tag allocation and out-of-order response routing.
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_shim_vtp_svc_arb #(
    parameter int N_CLIENTS       = 2,
    parameter int N_SVC_TAGS      = 8,
    parameter int CLIENT_TAG_BITS = 3,
    localparam int c_SVC_TAG_BITS = (N_SVC_TAGS > 1) ? $clog2(N_SVC_TAGS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,

    input  logic [N_CLIENTS-1:0]                 c_lookupEn,
    input  logic [36*N_CLIENTS-1:0]              c_lookupPageVA,
    input  logic [CLIENT_TAG_BITS*N_CLIENTS-1:0] c_lookupTag,
    output logic [N_CLIENTS-1:0]                 c_lookupRdy,
    output logic [N_CLIENTS-1:0]                 c_rspValid,
    output logic [25:0]                          c_rspPagePA,
    output logic [CLIENT_TAG_BITS-1:0]           c_rspTag,
    output logic                                 c_rspIsBigPage,

    output logic                                 s_lookupEn,
    output logic [35:0]                          s_lookupPageVA,
    output logic [c_SVC_TAG_BITS-1:0]            s_lookupTag,
    input  logic                                 s_lookupRdy,
    input  logic                                 s_rspValid,
    input  logic [25:0]                          s_rspPagePA,
    input  logic [c_SVC_TAG_BITS-1:0]            s_rspTag,
    input  logic                                 s_rspIsBigPage,

    output logic                                 err_badTag
);

    localparam int c_CLIENT_ID_BITS = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    logic [N_CLIENTS-1:0]        w_holdValid;
    logic [35:0]                 w_holdVA  [N_CLIENTS];
    logic [CLIENT_TAG_BITS-1:0]  w_holdTag [N_CLIENTS];
    logic [N_CLIENTS-1:0]        w_lookupRdy;
    logic [N_CLIENTS-1:0]        w_xfer;

    logic [c_CLIENT_ID_BITS-1:0] r_ptr;
    logic                        r_sEn;
    logic [35:0]                 r_sVA;
    logic [c_SVC_TAG_BITS-1:0]   r_sTag;

    logic [N_SVC_TAGS-1:0]       r_tagBusy;
    logic [c_CLIENT_ID_BITS-1:0] r_tagClient [N_SVC_TAGS];
    logic [CLIENT_TAG_BITS-1:0]  r_tagCTag   [N_SVC_TAGS];

    logic [N_CLIENTS-1:0]        r_rspValid;
    logic [25:0]                 r_rspPA;
    logic [CLIENT_TAG_BITS-1:0]  r_rspTag;
    logic                        r_rspBig;
    logic                        r_errBadTag;

    logic                        w_outCanLoad;
    logic                        w_anyFree;
    logic                        w_grant;
    logic [c_CLIENT_ID_BITS-1:0] w_winner;
    logic [c_CLIENT_ID_BITS-1:0] w_nextPtr;
    logic [c_SVC_TAG_BITS-1:0]   w_allocTag;
    logic                        w_rspKnown;
    logic                        w_rspHit;
    logic                        w_rspBad;
    logic [N_CLIENTS-1:0]        w_rspOneHot;

    assign w_xfer = c_lookupEn & w_lookupRdy;

    // One-entry hold per client; ready is the registered complement of the next fill state
    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_hold
        logic                       r_valid;
        logic [35:0]                r_va;
        logic [CLIENT_TAG_BITS-1:0] r_tag;
        logic                       r_rdy;
        logic                       w_granted;

        assign w_granted = w_grant && (int'(w_winner) == i);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_va    <= '0;
                r_tag   <= '0;
                r_rdy   <= 1'b0;
            end else begin
                if (w_xfer[i]) begin
                    r_valid <= 1'b1;
                    r_va    <= c_lookupPageVA[36*i +: 36];
                    r_tag   <= c_lookupTag[CLIENT_TAG_BITS*i +: CLIENT_TAG_BITS];
                end else if (w_granted) begin
                    r_valid <= 1'b0;
                end
                r_rdy <= ~w_xfer[i] & (w_granted | ~r_valid);
            end
        end

        assign w_holdValid[i] = r_valid;
        assign w_holdVA[i]    = r_va;
        assign w_holdTag[i]   = r_tag;
        assign w_lookupRdy[i] = r_rdy;
    end

    assign w_outCanLoad = ~r_sEn | s_lookupRdy;
    assign w_anyFree    = ~&r_tagBusy;
    assign w_grant      = w_outCanLoad & w_anyFree & (|w_holdValid);

    // Descending scan so the lowest offset from the pointer wins
    always_comb begin
        int idx;
        idx      = 0;
        w_winner = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
            if (w_holdValid[c_CLIENT_ID_BITS'(idx)]) w_winner = c_CLIENT_ID_BITS'(idx);
        end
    end

    assign w_nextPtr = (int'(w_winner) == N_CLIENTS - 1) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_allocTag = '0;
        for (int t = N_SVC_TAGS - 1; t >= 0; t--) begin
            if (!r_tagBusy[c_SVC_TAG_BITS'(t)]) w_allocTag = c_SVC_TAG_BITS'(t);
        end
    end

    assign w_rspKnown = (int'(s_rspTag) < N_SVC_TAGS) && r_tagBusy[s_rspTag];
    assign w_rspHit   = s_rspValid & w_rspKnown;
    assign w_rspBad   = s_rspValid & ~w_rspKnown;

    always_comb begin
        w_rspOneHot = '0;
        w_rspOneHot[r_tagClient[s_rspTag]] = w_rspHit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= '0;
            r_sEn  <= 1'b0;
            r_sVA  <= '0;
            r_sTag <= '0;
        end else begin
            if (w_grant) begin
                r_ptr  <= w_nextPtr;
                r_sEn  <= 1'b1;
                r_sVA  <= w_holdVA[w_winner];
                r_sTag <= w_allocTag;
            end else if (s_lookupRdy) begin
                r_sEn  <= 1'b0;
            end
        end
    end

    // A grant only sees tags busy before this edge, so a same-edge free never collides
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tagBusy <= '0;
            for (int t = 0; t < N_SVC_TAGS; t++) begin
                r_tagClient[t] <= '0;
                r_tagCTag[t]   <= '0;
            end
        end else begin
            if (w_rspHit) r_tagBusy[s_rspTag] <= 1'b0;
            if (w_grant) begin
                r_tagBusy[w_allocTag]   <= 1'b1;
                r_tagClient[w_allocTag] <= w_winner;
                r_tagCTag[w_allocTag]   <= w_holdTag[w_winner];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rspValid  <= '0;
            r_rspPA     <= '0;
            r_rspTag    <= '0;
            r_rspBig    <= 1'b0;
            r_errBadTag <= 1'b0;
        end else begin
            r_rspValid <= w_rspOneHot;
            if (w_rspHit) begin
                r_rspPA  <= s_rspPagePA;
                r_rspTag <= r_tagCTag[s_rspTag];
                r_rspBig <= s_rspIsBigPage;
            end
            if (w_rspBad) r_errBadTag <= 1'b1;
        end
    end

    assign c_lookupRdy    = w_lookupRdy;
    assign c_rspValid     = r_rspValid;
    assign c_rspPagePA    = r_rspPA;
    assign c_rspTag       = r_rspTag;
    assign c_rspIsBigPage = r_rspBig;
    assign s_lookupEn     = r_sEn;
    assign s_lookupPageVA = r_sVA;
    assign s_lookupTag    = r_sTag;
    assign err_badTag     = r_errBadTag;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_shim_vtp_svc_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_shim_vtp_svc_arb
// Brief    : Self-checking bench with a behavioural model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_mpf_shim_vtp_svc_arb;

    localparam int N   = 2;
    localparam int T   = 8;
    localparam int CTB = 3;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic [N-1:0]     cEn     = '0;
    logic [36*N-1:0]  cVA     = '0;
    logic [CTB*N-1:0] cTag    = '0;
    logic [N-1:0]     cRdy;
    logic [N-1:0]     cRspV;
    logic [25:0]      cPA;
    logic [CTB-1:0]   cRspTag;
    logic             cBig;
    logic             sEn;
    logic [35:0]      sVA;
    logic [2:0]       sTag;
    logic             sRdy    = 1'b0;
    logic             sRspV   = 1'b0;
    logic [25:0]      sPA     = '0;
    logic [2:0]       sRspTag = '0;
    logic             sBig    = 1'b0;
    logic             errBad;

    cci_mpf_shim_vtp_svc_arb #(
        .N_CLIENTS(N), .N_SVC_TAGS(T), .CLIENT_TAG_BITS(CTB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .c_lookupEn(cEn), .c_lookupPageVA(cVA), .c_lookupTag(cTag),
        .c_lookupRdy(cRdy), .c_rspValid(cRspV), .c_rspPagePA(cPA),
        .c_rspTag(cRspTag), .c_rspIsBigPage(cBig),
        .s_lookupEn(sEn), .s_lookupPageVA(sVA), .s_lookupTag(sTag),
        .s_lookupRdy(sRdy), .s_rspValid(sRspV), .s_rspPagePA(sPA),
        .s_rspTag(sRspTag), .s_rspIsBigPage(sBig),
        .err_badTag(errBad)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    bit started = 0;

    // Behavioural model state
    logic [N-1:0]   mHoldV;
    logic [35:0]    mHoldVA  [N];
    logic [CTB-1:0] mHoldTag [N];
    logic [N-1:0]   mRdy;
    int             mPtr;
    logic           mSEn;
    logic [35:0]    mSVA;
    logic [2:0]     mSTag;
    logic [T-1:0]   mBusy;
    int             mOwner  [T];
    logic [CTB-1:0] mOwnTag [T];
    logic [N-1:0]   mRspV;
    logic [25:0]    mPA;
    logic [CTB-1:0] mRspTag;
    logic           mBig;
    logic           mErr;
    logic [2:0]     svcQ[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mHoldV = '0; mRdy = '0; mPtr = 0;
        mSEn = 1'b0; mSVA = '0; mSTag = '0;
        mBusy = '0; mRspV = '0; mPA = '0; mRspTag = '0; mBig = 1'b0; mErr = 1'b0;
        for (int i = 0; i < N; i++) begin mHoldVA[i] = '0; mHoldTag[i] = '0; end
        for (int t = 0; t < T; t++) begin mOwner[t] = 0; mOwnTag[t] = '0; end
    endtask

    task automatic modelStep();
        bit canLoad, accepted, grant;
        int freeTag, win, c, t;
        logic [N-1:0] newRsp;
        if (!reset_n) begin
            modelReset();
            return;
        end
        canLoad  = !mSEn || sRdy;
        accepted = mSEn && sRdy;
        freeTag  = -1;
        for (int k = 0; k < T; k++) if (!mBusy[k] && freeTag < 0) freeTag = k;
        win = -1;
        for (int k = 0; k < N; k++) begin
            c = (mPtr + k) % N;
            if (mHoldV[c] && win < 0) win = c;
        end
        grant = canLoad && (freeTag >= 0) && (win >= 0);
        if (accepted) svcQ.push_back(mSTag);

        newRsp = '0;
        if (sRspV) begin
            t = int'(sRspTag);
            if (mBusy[t]) begin
                newRsp[mOwner[t]] = 1'b1;
                mRspTag  = mOwnTag[t];
                mPA      = sPA;
                mBig     = sBig;
                mBusy[t] = 1'b0;
            end else begin
                mErr = 1'b1;
            end
        end
        mRspV = newRsp;

        if (grant) begin
            mSEn = 1'b1;
            mSVA = mHoldVA[win];
            mSTag = 3'(freeTag);
            mBusy[freeTag]   = 1'b1;
            mOwner[freeTag]  = win;
            mOwnTag[freeTag] = mHoldTag[win];
            mHoldV[win] = 1'b0;
            mPtr = (win + 1) % N;
        end else if (accepted) begin
            mSEn = 1'b0;
        end

        for (int i = 0; i < N; i++) begin
            if (cEn[i] && mRdy[i]) begin
                mHoldV[i]   = 1'b1;
                mHoldVA[i]  = cVA[36*i +: 36];
                mHoldTag[i] = cTag[CTB*i +: CTB];
            end
        end
        for (int i = 0; i < N; i++) mRdy[i] = !mHoldV[i];
    endtask

    always @(posedge clk) if (started) modelStep();

    always @(negedge clk) begin
        if (started) begin
            check("c_lookupRdy", cRdy, mRdy);
            check("s_lookupEn", sEn, mSEn);
            if (mSEn) begin
                check("s_lookupPageVA", sVA, mSVA);
                check("s_lookupTag", sTag, mSTag);
            end
            check("c_rspValid", cRspV, mRspV);
            if (mRspV != '0) begin
                check("c_rspPagePA", cPA, mPA);
                check("c_rspTag", cRspTag, mRspTag);
                check("c_rspIsBigPage", cBig, mBig);
            end
            check("err_badTag", errBad, mErr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input int tag, input logic [25:0] pa, input logic big);
        sRspV = 1'b1; sRspTag = 3'(tag); sPA = pa; sBig = big;
        for (int k = 0; k < svcQ.size(); k++) begin
            if (int'(svcQ[k]) == tag) begin svcQ.delete(k); break; end
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        cEn = '0; sRdy = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (svcQ.size() > 0) begin
                sRspV = 1'b1; sRspTag = svcQ.pop_front();
                sPA = 26'($urandom()); sBig = 1'($urandom());
            end else begin
                sRspV = 1'b0;
            end
            tick();
            if (svcQ.size() == 0 && mBusy == '0 && !mSEn && mHoldV == '0) done = 1;
        end
        sRspV = 1'b0;
        tick();
        check("drain_complete", 64'(done), 64'd1);
    endtask

    task automatic sendOne(input int client, input logic [35:0] va, input logic [2:0] tag);
        cEn = '0;
        cEn[client] = 1'b1;
        cVA[36*client +: 36] = va;
        cTag[CTB*client +: CTB] = tag;
        tick();
        cEn = '0;
        tick();
        tick();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        modelReset();
        svcQ.delete();
        sRspV = 1'b0; cEn = '0;
        #1;
        check("rst_c_lookupRdy", cRdy, 0);
        check("rst_s_lookupEn", sEn, 0);
        check("rst_s_lookupPageVA", sVA, 0);
        check("rst_s_lookupTag", sTag, 0);
        check("rst_c_rspValid", cRspV, 0);
        check("rst_c_rspPagePA", cPA, 0);
        check("rst_c_rspTag", cRspTag, 0);
        check("rst_c_rspIsBigPage", cBig, 0);
        check("rst_err_badTag", errBad, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_rdy", cRdy, 2'b11);
        check("post_rst_err", errBad, 0);
    endtask

    initial begin
        int got;
        #2;
        started = 1;
        doReset();

        // Single request from client 1
        sRdy = 1'b1;
        cEn = 2'b10; cVA[71:36] = 36'h123456789; cTag[5:3] = 3'd5;
        tick();
        cEn = '0;
        check("single_rdy_full", cRdy, 2'b01);
        check("single_not_yet", sEn, 0);
        tick();
        check("single_sEn", sEn, 1);
        check("single_sTag", sTag, 0);
        check("single_sVA", sVA, 36'h123456789);
        tick();
        respond(0, 26'h0ABCDEF, 1'b1);
        tick();
        sRspV = 1'b0;
        check("single_rspValid", cRspV, 2'b10);
        check("single_rspTag", cRspTag, 5);
        check("single_rspPA", cPA, 26'h0ABCDEF);
        check("single_rspBig", cBig, 1);
        tick();
        check("single_rspValid_clear", cRspV, 0);

        // Fairness: both clients streaming
        cEn = 2'b11; cVA = {36'hB00000001, 36'hA00000000}; cTag = {3'd6, 3'd2};
        got = 0;
        for (int i = 0; i < 12 && got < 4; i++) begin
            tick();
            if (sEn) begin
                check("fair_va", sVA, (got % 2 == 1) ? 36'hB00000001 : 36'hA00000000);
                check("fair_tag", sTag, 64'(got));
                got++;
            end
        end
        cEn = '0;
        check("fair_count", 64'(got), 4);
        drain();

        // Exhaustion: client 0 streams with no responses
        cEn = 2'b01; cTag[2:0] = 3'd7; got = 0;
        for (int i = 0; i < 20; i++) begin
            cVA[35:0] = 36'(i + 256);
            tick();
            if (sEn) got++;
        end
        check("exh_grants", 64'(got), 8);
        check("exh_rdy0", cRdy[0], 0);
        check("exh_idle", sEn, 0);
        cEn = '0;
        respond(3, 26'h1, 1'b0);
        tick();
        sRspV = 1'b0;
        check("exh_rsp", cRspV, 2'b01);
        check("exh_no_same_edge", sEn, 0);
        tick();
        check("exh_regrant", sEn, 1);
        check("exh_regrant_tag", sTag, 3);
        drain();

        // Out-of-order responses
        sendOne(0, 36'h111, 3'd1);
        sendOne(1, 36'h222, 3'd2);
        sendOne(0, 36'h333, 3'd3);
        respond(2, 26'h22, 1'b0);
        tick();
        check("ooo_a_valid", cRspV, 2'b01);
        check("ooo_a_tag", cRspTag, 3);
        respond(0, 26'h00, 1'b1);
        tick();
        check("ooo_b_valid", cRspV, 2'b01);
        check("ooo_b_tag", cRspTag, 1);
        respond(1, 26'h11, 1'b0);
        tick();
        sRspV = 1'b0;
        check("ooo_c_valid", cRspV, 2'b10);
        check("ooo_c_tag", cRspTag, 2);
        tick();

        // Backpressure on the service side
        sRdy = 1'b0;
        cEn = 2'b10; cVA[71:36] = 36'hFEDCBA987; cTag[5:3] = 3'd4;
        tick();
        cEn = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_sEn", sEn, 1);
            check("bp_sVA", sVA, 36'hFEDCBA987);
            check("bp_sTag", sTag, 0);
            tick();
        end
        sRdy = 1'b1;
        tick();
        check("bp_accept_once", sEn, 0);
        tick();
        check("bp_still_idle", sEn, 0);
        drain();

        // Randomized traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int k;
            for (int i = 0; i < N; i++) begin
                cEn[i] = ($urandom_range(0, 99) < 60);
                cVA[36*i +: 36] = 36'({$urandom(), $urandom()});
                cTag[CTB*i +: CTB] = 3'($urandom());
            end
            sRdy = ($urandom_range(0, 99) < 70);
            if (svcQ.size() > 0 && $urandom_range(0, 99) < 45) begin
                k = $urandom_range(0, svcQ.size() - 1);
                sRspV = 1'b1; sRspTag = svcQ[k]; svcQ.delete(k);
                sPA = 26'($urandom()); sBig = 1'($urandom());
            end else begin
                sRspV = 1'b0;
            end
            tick();
        end
        drain();

        // Bad tag, then reset with a request in flight
        sRspV = 1'b1; sRspTag = 3'd6; sPA = 26'h3; sBig = 1'b0;
        tick();
        sRspV = 1'b0;
        check("bad_err", errBad, 1);
        check("bad_no_rsp", cRspV, 0);
        sendOne(0, 36'h0CAFE, 3'd1);
        doReset();
        sRspV = 1'b1; sRspTag = 3'd0;
        tick();
        sRspV = 1'b0;
        check("stale_err", errBad, 1);
        check("stale_no_rsp", cRspV, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
